// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//
// Purpose:
//   Sits directly upstream of a 1024 x 8 level-sensitive RAM and is the only
//   agent driving its Enable/ReadWrite/Address/DataIn pins. Accepts single or
//   burst (1..2**LEN_WIDTH beats) read/write requests over a valid/ready
//   handshake. Each write beat is sequenced SETUP -> STROBE -> HOLD so that
//   address, data and direction are stable for the whole strobe. Read data is
//   returned over a valid/ready stream with a last-beat marker.
//
// Ports:
//   Clock, Reset         single clock, synchronous active-high reset
//   ReqValid/ReqReady    request handshake (ReqReady high only in IDLE)
//   ReqReadWrite         1 = read, 0 = write
//   ReqAddress           first beat address
//   ReqLength            number of beats minus one
//   WrValid/WrReady      write beat handshake (WrReady high only in WR_WAIT)
//   WrData               write beat data
//   RdValid/RdReady      read beat handshake
//   RdData, RdLast       registered read beat data and final-beat marker
//   Busy                 controller is not idle
//   MemEnable            RAM Enable (registered)
//   MemReadWrite         RAM ReadWrite (registered, 1 = read)
//   MemAddress           RAM Address (registered)
//   MemDataIn            RAM DataIn (registered)
//   MemDataOut           RAM DataOut
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqReadWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [LEN_WIDTH-1:0]  ReqLength,
  input  logic                  WrValid,
  output logic                  WrReady,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic                  RdValid,
  input  logic                  RdReady,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdLast,
  output logic                  Busy,
  output logic                  MemEnable,
  output logic                  MemReadWrite,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemDataIn,
  input  logic [DATA_WIDTH-1:0] MemDataOut
);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_DRIVE,
    RD_OUT
  } state_t;

  state_t state;
  state_t next_state;

  // Beats remaining after the current one; zero means this is the last beat.
  logic [LEN_WIDTH-1:0] beat_count;

  logic req_fire;
  logic wr_fire;
  logic rd_fire;
  logic last_beat;

  assign ReqReady  = (state == IDLE);
  assign WrReady   = (state == WR_WAIT);
  assign Busy      = (state != IDLE);
  assign req_fire  = ReqValid & ReqReady;
  assign wr_fire   = WrValid & WrReady;
  assign rd_fire   = RdReady & RdValid & (state == RD_OUT);
  assign last_beat = (beat_count == '0);

  // Next-state logic. The direction of a burst is encoded by which branch of
  // the state machine it runs in, so no separate direction register is kept.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          next_state = ReqReadWrite ? RD_DRIVE : WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_fire) begin
          next_state = WR_SETUP;
        end
      end
      WR_SETUP:  next_state = WR_STROBE;
      WR_STROBE: next_state = WR_HOLD;
      WR_HOLD:   next_state = last_beat ? IDLE : WR_WAIT;
      RD_DRIVE:  next_state = RD_OUT;
      RD_OUT: begin
        if (rd_fire) begin
          next_state = RdLast ? IDLE : RD_DRIVE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  // State register plus all registered RAM-side and read-stream outputs.
  // Every Mem* pin is set on the edge that enters the state needing it, so
  // the pins never glitch and never move while MemEnable is high: address
  // and data only change on edges where MemEnable is already low or is
  // being raised for a read (the RAM only drives data, so that is harmless).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      beat_count   <= '0;
      MemEnable    <= 1'b0;
      MemReadWrite <= 1'b1;
      MemAddress   <= '0;
      MemDataIn    <= '0;
      RdValid      <= 1'b0;
      RdLast       <= 1'b0;
      RdData       <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_fire) begin
            MemAddress <= ReqAddress;
            beat_count <= ReqLength;
            // A read drives the RAM immediately so data is ready next edge.
            MemEnable  <= ReqReadWrite;
          end
        end
        WR_WAIT: begin
          if (wr_fire) begin
            MemDataIn    <= WrData;
            MemReadWrite <= 1'b0;
          end
        end
        WR_SETUP: begin
          MemEnable <= 1'b1;
        end
        WR_STROBE: begin
          MemEnable <= 1'b0;
        end
        WR_HOLD: begin
          // The strobe is over, so the pins may move again. Direction goes
          // back to read between beats as well as at the end of the burst.
          MemReadWrite <= 1'b1;
          if (!last_beat) begin
            MemAddress <= MemAddress + 1'b1;
            beat_count <= beat_count - 1'b1;
          end
        end
        RD_DRIVE: begin
          RdData    <= MemDataOut;
          RdLast    <= last_beat;
          RdValid   <= 1'b1;
          MemEnable <= 1'b0;
        end
        RD_OUT: begin
          if (rd_fire) begin
            RdValid <= 1'b0;
            RdLast  <= 1'b0;
            if (!RdLast) begin
              MemAddress <= MemAddress + 1'b1;
              beat_count <= beat_count - 1'b1;
              MemEnable  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//
// Purpose:
//   Self-checking bench for mem_access_ctrl. A behavioural 1024 x 8 RAM is
//   attached to the Mem* pins; a table of directed transactions with
//   hand-computed data is replayed, followed by hand-written sequences for
//   long bursts, requests arriving while busy, and reset mid-burst.
//
// Ports: none (top-level bench).
module tb_mem_access_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic          ReqReadWrite = 1'b0;
  logic [AW-1:0] ReqAddress = '0;
  logic [LW-1:0] ReqLength = '0;
  logic          WrValid = 1'b0;
  logic          WrReady;
  logic [DW-1:0] WrData = '0;
  logic          RdValid;
  logic          RdReady = 1'b0;
  logic [DW-1:0] RdData;
  logic          RdLast;
  logic          Busy;
  logic          MemEnable;
  logic          MemReadWrite;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemDataIn;
  logic [DW-1:0] MemDataOut;

  logic [DW-1:0] ram [1024];
  logic          ram_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int violations = 0;

  logic          prev_en = 1'b0;
  logic          prev_rw = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  mem_access_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqReadWrite(ReqReadWrite),
    .ReqAddress  (ReqAddress),
    .ReqLength   (ReqLength),
    .WrValid     (WrValid),
    .WrReady     (WrReady),
    .WrData      (WrData),
    .RdValid     (RdValid),
    .RdReady     (RdReady),
    .RdData      (RdData),
    .RdLast      (RdLast),
    .Busy        (Busy),
    .MemEnable   (MemEnable),
    .MemReadWrite(MemReadWrite),
    .MemAddress  (MemAddress),
    .MemDataIn   (MemDataIn),
    .MemDataOut  (MemDataOut)
  );

  always #5 Clock = ~Clock;

  // Level-sensitive RAM: reads are combinational from the address pins.
  assign MemDataOut = ram[MemAddress];

  // Known power-up pattern so untouched locations can be recognised.
  function automatic logic [DW-1:0] initByte(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  // RAM write model plus pin monitor. Pins are registered, so sampling once
  // per cycle at the falling edge sees the whole cycle's value. Counts enable
  // pulses and flags any pin movement across a strobe or a write strobe not
  // preceded by a matching setup cycle.
  always @(negedge Clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] = initByte(10'(i));
      ram_ready = 1'b1;
    end
    if (MemEnable && !MemReadWrite) ram[MemAddress] = MemDataIn;
    if (MemEnable && !prev_en) pulses++;
    if (prev_en && (MemAddress != prev_addr || MemDataIn != prev_data ||
                    MemReadWrite != prev_rw)) violations++;
    if (MemEnable && !MemReadWrite &&
        (MemAddress != prev_addr || MemDataIn != prev_data || prev_rw)) violations++;
    prev_en   = MemEnable;
    prev_rw   = MemReadWrite;
    prev_addr = MemAddress;
    prev_data = MemDataIn;
  end

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            gap;
    int            stall;
    logic [15:0][DW-1:0] data;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic setVec(input int idx, input logic rd, input logic [AW-1:0] addr,
                        input logic [LW-1:0] len, input int gap, input int stall,
                        input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                        input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    vecs[idx].rd    = rd;
    vecs[idx].addr  = addr;
    vecs[idx].len   = len;
    vecs[idx].gap   = gap;
    vecs[idx].stall = stall;
    vecs[idx].data  = '0;
    vecs[idx].data[0] = b0;
    vecs[idx].data[1] = b1;
    vecs[idx].data[2] = b2;
    vecs[idx].data[3] = b3;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_en"},     32'(MemEnable), 32'd0);
    checkOutput({tag, "_rw"},     32'(MemReadWrite), 32'd1);
    checkOutput({tag, "_addr"},   32'(MemAddress), 32'd0);
    checkOutput({tag, "_din"},    32'(MemDataIn), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(RdValid), 32'd0);
    checkOutput({tag, "_rlast"},  32'(RdLast), 32'd0);
    checkOutput({tag, "_rdata"},  32'(RdData), 32'd0);
    checkOutput({tag, "_busy"},   32'(Busy), 32'd0);
    checkOutput({tag, "_reqrdy"}, 32'(ReqReady), 32'd1);
    checkOutput({tag, "_wrrdy"},  32'(WrReady), 32'd0);
  endtask

  // Runs one complete transaction from IDLE with cycle-exact expectations:
  // write beats take 4 cycles plus any WrValid gap, read beats take 2 cycles
  // plus any RdReady stall on the first beat.
  task automatic applyStimulus(input vec_t v);
    int n;
    int p0;
    logic [AW-1:0] a;
    logic [DW-1:0] held;
    n  = int'(v.len) + 1;
    p0 = pulses;
    checkOutput("req_ready_idle", 32'(ReqReady), 32'd1);
    ReqValid     = 1'b1;
    ReqReadWrite = v.rd;
    ReqAddress   = v.addr;
    ReqLength    = v.len;
    if (v.rd) RdReady = (v.stall == 0);
    tick();
    ReqValid = 1'b0;
    if (!v.rd) begin
      for (int b = 0; b < n; b++) begin
        a = v.addr + 10'(b);
        if (b > 0) begin
          for (int g = 0; g < v.gap; g++) begin
            checkOutput("gap_en", 32'(MemEnable), 32'd0);
            checkOutput("gap_wrrdy", 32'(WrReady), 32'd1);
            tick();
          end
        end
        checkOutput("wr_ready", 32'(WrReady), 32'd1);
        WrValid = 1'b1;
        WrData  = v.data[b];
        tick();
        WrValid = 1'b0;
        WrData  = 8'hFF;
        checkOutput("setup_en", 32'(MemEnable), 32'd0);
        checkOutput("setup_rw", 32'(MemReadWrite), 32'd0);
        checkOutput("setup_addr", 32'(MemAddress), 32'(a));
        checkOutput("setup_din", 32'(MemDataIn), 32'(v.data[b]));
        tick();
        checkOutput("strobe_en", 32'(MemEnable), 32'd1);
        checkOutput("strobe_addr", 32'(MemAddress), 32'(a));
        checkOutput("strobe_din", 32'(MemDataIn), 32'(v.data[b]));
        tick();
        checkOutput("hold_en", 32'(MemEnable), 32'd0);
        checkOutput("hold_busy", 32'(Busy), 32'd1);
        tick();
      end
      checkOutput("wr_done_busy", 32'(Busy), 32'd0);
      checkOutput("wr_done_rw", 32'(MemReadWrite), 32'd1);
      checkOutput("wr_pulses", 32'(pulses - p0), 32'(n));
      for (int b = 0; b < n; b++) begin
        a = v.addr + 10'(b);
        checkOutput("ram_content", 32'(ram[a]), 32'(v.data[b]));
      end
    end else begin
      for (int b = 0; b < n; b++) begin
        tick();
        checkOutput("rd_valid", 32'(RdValid), 32'd1);
        checkOutput("rd_data", 32'(RdData), 32'(v.data[b]));
        checkOutput("rd_last", 32'(RdLast), 32'(b == n - 1));
        if (b == 0 && v.stall > 0) begin
          held = RdData;
          for (int s = 0; s < v.stall; s++) begin
            tick();
            checkOutput("stall_valid", 32'(RdValid), 32'd1);
            checkOutput("stall_data", 32'(RdData), 32'(held));
            checkOutput("stall_en", 32'(MemEnable), 32'd0);
          end
          RdReady = 1'b1;
        end
        tick();
        checkOutput("rd_valid_drop", 32'(RdValid), 32'd0);
        if (b < n - 1) checkOutput("rd_next_en", 32'(MemEnable), 32'd1);
      end
      checkOutput("rd_done_busy", 32'(Busy), 32'd0);
      checkOutput("rd_pulses", 32'(pulses - p0), 32'(n));
      RdReady = 1'b0;
    end
  endtask

  initial begin
    vec_t big;
    logic [AW-1:0] a;

    setVec(0, 1'b0, 10'd3,    4'd0, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00);
    setVec(1, 1'b1, 10'd3,    4'd0, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00);
    setVec(2, 1'b0, 10'd1022, 4'd3, 0, 0, 8'hAA, 8'h0A, 8'h0B, 8'h0C);
    setVec(3, 1'b1, 10'd1022, 4'd3, 0, 0, 8'hAA, 8'h0A, 8'h0B, 8'h0C);
    setVec(4, 1'b0, 10'd100,  4'd1, 5, 0, 8'h11, 8'h22, 8'h00, 8'h00);
    setVec(5, 1'b1, 10'd100,  4'd1, 0, 3, 8'h11, 8'h22, 8'h00, 8'h00);
    setVec(6, 1'b1, 10'd0,    4'd0, 0, 0, 8'h0B, 8'h00, 8'h00, 8'h00);

    repeat (3) tick();
    Reset = 1'b0;
    checkResetValues("reset");

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // 16-beat read over an untouched region: power-up pattern comes back.
    big.rd = 1'b1; big.addr = 10'd500; big.len = 4'd15; big.gap = 0; big.stall = 0;
    for (int b = 0; b < 16; b++) begin
      a = 10'd500 + 10'(b);
      big.data[b] = initByte(a);
    end
    applyStimulus(big);

    // Request raised while a write is busy is held off until IDLE.
    ReqValid = 1'b1; ReqReadWrite = 1'b0; ReqAddress = 10'd300; ReqLength = 4'd0;
    tick();
    ReqReadWrite = 1'b1; ReqAddress = 10'd3; ReqLength = 4'd0;
    checkOutput("busy_reqrdy", 32'(ReqReady), 32'd0);
    WrValid = 1'b1; WrData = 8'h77;
    tick();
    WrValid = 1'b0;
    checkOutput("busy_reqrdy2", 32'(ReqReady), 32'd0);
    tick();
    tick();
    checkOutput("busy_hold_busy", 32'(Busy), 32'd1);
    tick();
    checkOutput("busy_idle_reqrdy", 32'(ReqReady), 32'd1);
    tick();
    ReqValid = 1'b0;
    RdReady  = 1'b1;
    checkOutput("busy_accept", 32'(Busy), 32'd1);
    tick();
    checkOutput("busy_rd_valid", 32'(RdValid), 32'd1);
    checkOutput("busy_rd_data", 32'(RdData), 32'h5A);
    checkOutput("busy_rd_last", 32'(RdLast), 32'd1);
    tick();
    RdReady = 1'b0;
    checkOutput("busy_done", 32'(Busy), 32'd0);
    checkOutput("busy_ram300", 32'(ram[10'd300]), 32'h77);

    // Reset in WR_HOLD of beat 2 of a 4-beat write, with a read request held
    // through reset that must be taken in the first cycle after.
    ReqValid = 1'b1; ReqReadWrite = 1'b0; ReqAddress = 10'd200; ReqLength = 4'd3;
    tick();
    ReqValid = 1'b0;
    WrValid = 1'b1; WrData = 8'hD1;
    tick();
    WrValid = 1'b0;
    repeat (3) tick();
    WrValid = 1'b1; WrData = 8'hD2;
    tick();
    WrValid = 1'b0;
    tick();
    tick();
    checkOutput("rst_in_hold_en", 32'(MemEnable), 32'd0);
    Reset = 1'b1;
    ReqValid = 1'b1; ReqReadWrite = 1'b1; ReqAddress = 10'd200; ReqLength = 4'd0;
    tick();
    Reset = 1'b0;
    checkResetValues("midrst");
    tick();
    ReqValid = 1'b0;
    RdReady  = 1'b1;
    tick();
    checkOutput("postrst_rd_valid", 32'(RdValid), 32'd1);
    checkOutput("postrst_rd_data", 32'(RdData), 32'hD1);
    tick();
    RdReady = 1'b0;
    checkOutput("midrst_ram200", 32'(ram[10'd200]), 32'hD1);
    checkOutput("midrst_ram201", 32'(ram[10'd201]), 32'hD2);
    checkOutput("midrst_ram202", 32'(ram[10'd202]), 32'h09);
    checkOutput("midrst_ram203", 32'(ram[10'd203]), 32'h08);

    checkOutput("pin_stability", 32'(violations), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Synchronous request-driven controller that sits directly upstream of the 1024 x 8 level-sensitive RAM and is the only agent driving its Enable/ReadWrite/Address/DataIn pins. Accepts single or burst (1-16 beat) read/write requests from the processor over valid/ready handshakes. Sequences the RAM pins so that address and data are stable for the whole time a write strobe is active. Returns read data over a valid/ready stream with a last-beat marker.

## Interface
- ADDR_WIDTH, 10, RAM address width (1024 locations)
- DATA_WIDTH, 8, RAM data width
- LEN_WIDTH, 4, burst length field width; beats = ReqLength + 1

- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  controller can accept a request; high only in IDLE
- ReqReadWrite  in  1  1 = read, 0 = write (same polarity as the RAM)
- ReqAddress  in  ADDR_WIDTH  first beat address
- ReqLength  in  LEN_WIDTH  beats minus one
- WrValid  in  1  write beat data present
- WrReady  out  1  controller takes write data; high only in WR_WAIT
- WrData  in  DATA_WIDTH  write beat data
- RdValid  out  1  read beat data present
- RdReady  in  1  consumer takes read beat
- RdData  out  DATA_WIDTH  read beat data, registered
- RdLast  out  1  qualifies final beat of a read burst
- Busy  out  1  state != IDLE
- MemEnable  out  1  to RAM Enable
- MemReadWrite  out  1  to RAM ReadWrite
- MemAddress  out  ADDR_WIDTH  to RAM Address
- MemDataIn  out  DATA_WIDTH  to RAM DataIn
- MemDataOut  in  DATA_WIDTH  from RAM DataOut

## Operation
- States: IDLE, WR_WAIT, WR_SETUP, WR_STROBE, WR_HOLD, RD_DRIVE, RD_OUT.
- IDLE: request handshake (ReqValid & ReqReady) latches address into MemAddress, length into beat counter, and direction. Next state is WR_WAIT (write) or RD_DRIVE (read).
- WR_WAIT: WrReady=1. The WrValid handshake registers WrData into MemDataIn, then the state moves to WR_SETUP.
- WR_SETUP: MemEnable=0, MemReadWrite=0, address and data stable.
- WR_STROBE: MemEnable=1, MemReadWrite=0, for exactly one cycle.
- WR_HOLD: MemEnable=0; address and data unchanged. If counter==0, go to IDLE and set MemReadWrite=1. Otherwise MemAddress+1, counter-1, go to WR_WAIT.
- RD_DRIVE: MemEnable=1, MemReadWrite=1. At end of cycle, MemDataOut is registered into RdData, RdLast=(counter==0), RdValid=1, and the state moves to RD_OUT.
- RD_OUT: MemEnable=0; RdData/RdLast held until RdReady. On the handshake: RdValid=0; if last, go to IDLE, else MemAddress+1, counter-1, go to RD_DRIVE.
- Address increment is modulo 2^ADDR_WIDTH: 1023 + 1 = 0, with no error.
- Ignored inputs:
  - ReqValid outside IDLE (ReqReady=0).
  - WrValid outside WR_WAIT.
  - RdReady while RdValid=0.
- Invariants:
  - MemAddress/MemDataIn never change while MemEnable=1.
  - MemReadWrite never changes while MemEnable=1.
  - MemReadWrite=1 whenever no write beat is in progress.
  - All Mem* outputs and RdData/RdValid/RdLast are registers.

## Timing
- Reset values: state IDLE, MemEnable=0, MemReadWrite=1, MemAddress=0, MemDataIn=0, RdValid=0, RdLast=0, RdData=0, Busy=0.
- ReqReady=1 in the first cycle after Reset deasserts.
- Reset mid-burst: controller returns to IDLE at that edge and remaining beats are dropped. MemEnable falls at that edge. A write whose WR_STROBE cycle completed stays written. RdValid clears.
- Write throughput, WrValid held high: 4 cycles/beat. An N-beat burst returns to IDLE 4N cycles after the request edge.
- Read latency: request accepted at edge E, RdValid high from edge E+1.
- Read throughput, RdReady held high: 2 cycles/beat.
- Back-to-back requests: the next ReqReady is high in the cycle after the burst returns to IDLE. No overlap.
- A request with ReqValid held through reset is accepted in the first post-reset cycle.

## Test plan
- Single write then read: write 0x5A to address 3, then read address 3 -> RdData=0x5A with RdLast=1. Check 1 MemEnable pulse per beat. Check MemAddress/MemDataIn stable while MemEnable=1.
- 4-beat write burst at address 1022 with data AA,0A,0B,0C -> RAM[1022]=AA, [1023]=0A, [0]=0B, [1]=0C. Then a 4-beat read from 1022 returns the same 4 bytes with RdLast only on the 4th beat.
- Backpressure:
  - WrValid low for 5 cycles between beats -> MemEnable stays 0 and no spurious write occurs.
  - RdReady low for 3 cycles -> RdData held constant and RdValid stays high.
- 16-beat read with RdReady always high -> RdValid at E+1, beats every 2 cycles, IDLE after 32 cycles.
- ReqValid asserted during a busy burst is ignored until IDLE, then accepted.
- Reset asserted in WR_HOLD of beat 2 of a 4-beat write -> beats 1-2 written, beats 3-4 untouched, all outputs at reset values next cycle.
